// File: rtl/fp_uni_pkg.sv
// ============================================================================
// fp_uni_pkg : unified FPALU result format and FP16 conversion constants
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_uni_pkg;
    localparam int UNI_EXP_W      = 6;
    localparam int UNI_MAN_W      = 22;
    localparam int FP16_W         = 16;
    localparam int UNI2FP16_EBIAS = 37;
    localparam logic [14:0] FP16_INF = 15'h7C00;

    typedef struct packed {
        logic                 sgn;
        logic [UNI_EXP_W-1:0] exp;
        logic [UNI_MAN_W-1:0] man;
    } uni_t;

    // Index of the most significant set bit; 0 when the mantissa is zero.
    function automatic logic [4:0] lead_one(input logic [UNI_MAN_W-1:0] m);
        lead_one = '0;
        for (int i = 0; i < UNI_MAN_W; i++) begin
            if (m[i]) lead_one = 5'(i);
        end
    endfunction
endpackage

`default_nettype wire

// File: rtl/fp_uni2fp16.sv
// ============================================================================
// fp_uni2fp16 : 2-stage unified-to-FP16 converter with round-to-nearest-even
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_uni2fp16
    import fp_uni_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  uni_t              uni_i,
    output logic              valid_o,
    output logic [FP16_W-1:0] word_o,
    output logic              flag_o,
    output logic [1:0]        occ_o
);
    logic              s1_v_q;
    uni_t              s1_uni_q;
    logic [4:0]        s1_p_q;
    logic signed [7:0] s1_e_q;
    logic              s2_v_q;
    logic [FP16_W-1:0] s2_word_q;
    logic              s2_flag_q;

    logic [4:0]        p_d;
    logic [7:0]        e_d;
    logic [20:0]       norm;
    logic [9:0]        nfrac;
    logic              ng, ns;
    logic [14:0]       nsum;
    logic [5:0]        sh_sub;
    logic [49:0]       sub;
    logic [9:0]        sm;
    logic              sg, ss;
    logic [14:0]       ssum;
    logic [FP16_W-1:0] word_d;
    logic              flag_d;

    assign p_d = lead_one(uni_i.man);
    assign e_d = 8'(p_d) + 8'(uni_i.exp) - 8'(UNI2FP16_EBIAS);

    always_comb begin
        // Normal path: leading one shifted to bit 21 (dropped by the truncation).
        norm   = 21'(s1_uni_q.man << (5'(UNI_MAN_W - 1) - s1_p_q));
        nfrac  = norm[20:11];
        ng     = norm[10];
        ns     = |norm[9:0];
        nsum   = {s1_e_q[4:0], nfrac} + 15'(ng & (ns | nfrac[0]));
        // Subnormal path: integer part lands in [49:40], guard at 39, sticky below.
        sh_sub = 6'(UNI2FP16_EBIAS) - s1_uni_q.exp;
        sub    = 50'({s1_uni_q.man, 9'b0, 40'b0} >> sh_sub);
        sm     = sub[49:40];
        sg     = sub[39];
        ss     = |sub[38:0];
        ssum   = {5'b0, sm} + 15'(sg & (ss | sm[0]));

        word_d = {s1_uni_q.sgn, 15'b0};
        flag_d = 1'b0;
        if (s1_uni_q.man != '0) begin
            if (s1_e_q > 8'sd30) begin
                word_d = {s1_uni_q.sgn, FP16_INF};
                flag_d = 1'b1;
            end else if (s1_e_q > 8'sd0) begin
                word_d = {s1_uni_q.sgn, nsum};
                flag_d = (nsum == FP16_INF);
            end else begin
                word_d = {s1_uni_q.sgn, ssum};
                flag_d = (ssum == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_uni_q  <= '0;
            s1_p_q    <= '0;
            s1_e_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_word_q <= '0;
            s2_flag_q <= 1'b0;
        end else begin
            s1_v_q <= valid_i & ~flush_i;
            s2_v_q <= s1_v_q & ~flush_i;
            if (valid_i) begin
                s1_uni_q <= uni_i;
                s1_p_q   <= p_d;
                s1_e_q   <= e_d;
            end
            if (s1_v_q) begin
                s2_word_q <= word_d;
                s2_flag_q <= flag_d;
            end
        end
    end

    assign valid_o = s2_v_q;
    assign word_o  = s2_word_q;
    assign flag_o  = s2_flag_q;
    assign occ_o   = {1'b0, s1_v_q} + {1'b0, s2_v_q};
endmodule

`default_nettype wire

// File: rtl/fpalu_wb.sv
// ============================================================================
// fpalu_wb : FPALU write-back - FP16 conversion, FIFO, data-memory streaming
// Rev 1.0
// ============================================================================
`default_nettype none

module fpalu_wb
    import fp_uni_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base,
    input  logic [ADDR_W-1:0]    len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sgn,
    input  logic [UNI_EXP_W-1:0] in_exp,
    input  logic [UNI_MAN_W-1:0] in_man_dn,
    output logic                 wr_en,
    input  logic                 wr_ready,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [FP16_W-1:0]    wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = CW + 2;

    logic              busy_q, done_q, ovf_q, unf_q, wr_en_q;
    logic [ADDR_W-1:0] len_q, acc_cnt_q, wr_cnt_q, addr_nxt_q, wr_addr_q;
    logic [FP16_W-1:0] wr_data_q;
    logic [FP16_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q;

    logic              conv_v, conv_flag;
    logic [FP16_W-1:0] conv_word;
    logic [1:0]        conv_occ;
    logic [IW-1:0]     inflight;
    logic              keep, push, pop, wr_hs;
    uni_t              uni_in;

    assign uni_in   = {in_sgn, in_exp, in_man_dn};
    // Credit covers pipeline, FIFO and the output register so the pipeline never stalls.
    assign inflight = IW'(cnt_q) + IW'(conv_occ) + IW'(wr_en_q);
    assign in_ready = busy_q & (inflight < IW'(DEPTH));
    assign keep     = in_valid & in_ready & ~start & (acc_cnt_q < len_q);
    assign push     = conv_v & ~start;
    assign pop      = (cnt_q != '0) & (~wr_en_q | wr_ready);
    assign wr_hs    = wr_en_q & wr_ready;

    fp_uni2fp16 u_conv (
        .clk     (clk),
        .rst     (rst),
        .flush_i (start),
        .valid_i (keep),
        .uni_i   (uni_in),
        .valid_o (conv_v),
        .word_o  (conv_word),
        .flag_o  (conv_flag),
        .occ_o   (conv_occ)
    );

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= conv_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            len_q      <= '0;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            addr_nxt_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else if (start) begin
            busy_q     <= (len != '0);
            done_q     <= (len == '0);
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            len_q      <= len;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            addr_nxt_q <= base;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (keep) acc_cnt_q <= acc_cnt_q + 1'b1;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);

            if (push && conv_flag) begin
                if (conv_word[14:0] == FP16_INF) ovf_q <= 1'b1;
                else                             unf_q <= 1'b1;
            end

            if (pop) begin
                wr_en_q    <= 1'b1;
                wr_data_q  <= mem_q[rptr_q];
                wr_addr_q  <= addr_nxt_q;
                addr_nxt_q <= addr_nxt_q + 1'b1;
            end else if (wr_hs) begin
                wr_en_q <= 1'b0;
            end

            if (wr_hs) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_cnt_q + 1'b1 == len_q) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
endmodule

`default_nettype wire

// File: tb/tb_fpalu_wb.sv
// ============================================================================
// tb_fpalu_wb : directed self-checking bench for fpalu_wb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fpalu_wb;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, in_sgn;
    logic [8:0]  base, len, wr_addr;
    logic [5:0]  in_exp;
    logic [21:0] in_man_dn;
    logic        wr_en, wr_ready, busy, done, ovf, unf;
    logic [15:0] wr_data;

    always #5 clk = ~clk;

    fpalu_wb #(.DEPTH(4), .ADDR_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_sgn(in_sgn),
        .in_exp(in_exp), .in_man_dn(in_man_dn), .wr_en(wr_en),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .ovf(ovf), .unf(unf)
    );

    typedef struct {
        logic [8:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;

    wr_t wq[$];
    int  checks = 0, failures = 0, cyc = 0, last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        wr_t w;
        if (wr_en && wr_ready) begin
            w.a = wr_addr;
            w.d = wr_data;
            w.c = cyc;
            wq.push_back(w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic sync();
        @(posedge clk); #2;
    endtask

    task automatic do_start(input logic [8:0] b, input logic [8:0] l);
        base = b; len = l; start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic send(input logic s, input logic [5:0] e, input logic [21:0] m);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; in_sgn = s; in_exp = e; in_man_dn = m;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            sync();
        end
        in_valid = 1'b0;
        last_acc = cyc;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_writes(input int n);
        for (int k = 0; k < 200 && wq.size() < n; k++) begin
            @(negedge clk); #1;
        end
        chk("nwrites", wq.size(), n);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk); #1;
        end
        chk("done", done, 1);
    endtask

    task automatic chk_wr(input int i, input logic [8:0] a, input logic [15:0] d);
        if (i < wq.size()) begin
            chk($sformatf("wr%0d_addr", i), wq[i].a, a);
            chk($sformatf("wr%0d_data", i), wq[i].d, d);
        end else begin
            chk($sformatf("wr%0d_missing", i), wq.size(), i + 1);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_wr_en"},    wr_en,    0);
        chk({pfx, "_wr_addr"},  wr_addr,  0);
        chk({pfx, "_wr_data"},  wr_data,  0);
        chk({pfx, "_busy"},     busy,     0);
        chk({pfx, "_done"},     done,     0);
        chk({pfx, "_ovf"},      ovf,      0);
        chk({pfx, "_unf"},      unf,      0);
    endtask

    initial begin
        int  first, acc;
        bit  took;
        rst = 1'b1; start = 1'b0; base = '0; len = '0;
        in_valid = 1'b0; in_sgn = 1'b0; in_exp = '0; in_man_dn = '0; wr_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        sync();
        rst = 1'b0; wr_ready = 1'b1;
        sync();

        // Basic conversions and latency
        wq.delete();
        do_start(9'h010, 9'd3);
        chk("basic_busy", busy, 1);
        chk("basic_in_ready", in_ready, 1);
        send(1'b0, 6'd31, 22'h200000);
        first = last_acc;
        send(1'b1, 6'd31, 22'h300000);
        send(1'b0, 6'd31, 22'h000000);
        wait_writes(3);
        chk("basic_done_early", done, 0);
        @(negedge clk);
        chk("basic_done_after_last", done, 1);
        chk("basic_busy_after_last", busy, 0);
        if (wq.size() > 0) chk("basic_latency", wq[0].c - first, 3);
        chk_wr(0, 9'h010, 16'h3C00);
        chk_wr(1, 9'h011, 16'hBE00);
        chk_wr(2, 9'h012, 16'h0000);

        // Round-to-nearest-even ties and carry into exponent
        sync(); wq.delete();
        do_start(9'h020, 9'd3);
        send(1'b0, 6'd31, 22'h200400);
        send(1'b0, 6'd31, 22'h200C00);
        send(1'b0, 6'd31, 22'h3FFFFF);
        wait_writes(3);
        wait_done();
        chk_wr(0, 9'h020, 16'h3C00);
        chk_wr(1, 9'h021, 16'h3C02);
        chk_wr(2, 9'h022, 16'h4000);
        chk("rne_ovf", ovf, 0);
        chk("rne_unf", unf, 0);

        // Range extremes
        sync(); wq.delete();
        do_start(9'h030, 9'd3);
        send(1'b0, 6'd63, 22'h200000);
        send(1'b0, 6'd28, 22'h000001);
        send(1'b0, 6'd20, 22'h000001);
        wait_writes(3);
        wait_done();
        chk_wr(0, 9'h030, 16'h7C00);
        chk_wr(1, 9'h031, 16'h0001);
        chk_wr(2, 9'h032, 16'h0000);
        chk("range_ovf", ovf, 1);
        chk("range_unf", unf, 1);

        // Backpressure: credit limit, hold-stable outputs, ordered drain
        sync(); wq.delete(); wr_ready = 1'b0;
        do_start(9'h040, 9'd8);
        chk("bp_ovf_cleared", ovf, 0);
        chk("bp_unf_cleared", unf, 0);
        acc = 0; in_valid = 1'b1; in_sgn = 1'b0; in_exp = 6'd31;
        for (int k = 0; k < 12; k++) begin
            in_man_dn = 22'h200000 | 22'(acc << 11);
            @(negedge clk);
            took = in_ready;
            sync();
            if (took) acc++;
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_no_write", wq.size(), 0);
        chk("bp_wr_en", wr_en, 1);
        chk("bp_hold_addr", wr_addr, 9'h040);
        chk("bp_hold_data", wr_data, 16'h3C00);
        wr_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(1'b0, 6'd31, 22'h200000 | 22'(i << 11));
        wait_writes(8);
        for (int i = 0; i < 8; i++) chk_wr(i, 9'h040 + 9'(i), 16'h3C00 + 16'(i));
        wait_done();

        // Address wrap and dropped overrun input
        sync(); wq.delete();
        do_start(9'h1FF, 9'd2);
        send(1'b0, 6'd31, 22'h200000);
        send(1'b1, 6'd31, 22'h200000);
        send(1'b0, 6'd31, 22'h300000);
        wait_writes(2);
        repeat (8) @(negedge clk);
        chk("wrap_count", wq.size(), 2);
        chk_wr(0, 9'h1FF, 16'h3C00);
        chk_wr(1, 9'h000, 16'hBC00);
        chk("wrap_done", done, 1);

        // Abort with start mid-job
        sync(); wq.delete(); wr_ready = 1'b0;
        do_start(9'h080, 9'd4);
        send(1'b0, 6'd31, 22'h200000);
        send(1'b0, 6'd31, 22'h200800);
        repeat (5) sync();
        chk("abort_pre_wr_en", wr_en, 1);
        do_start(9'h0C0, 9'd2);
        chk("abort_wr_en_drop", wr_en, 0);
        chk("abort_busy", busy, 1);
        wr_ready = 1'b1;
        send(1'b0, 6'd31, 22'h200000);
        send(1'b0, 6'd31, 22'h280000);
        wait_writes(2);
        repeat (8) @(negedge clk);
        chk("abort_count", wq.size(), 2);
        chk_wr(0, 9'h0C0, 16'h3C00);
        chk_wr(1, 9'h0C1, 16'h3D00);

        // Asynchronous reset in the middle of a stalled write
        sync(); wq.delete(); wr_ready = 1'b0;
        do_start(9'h100, 9'd2);
        send(1'b0, 6'd63, 22'h200000);
        repeat (5) sync();
        chk("rst_pre_wr_en", wr_en, 1);
        chk("rst_pre_ovf", ovf, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        sync(); sync();
        rst = 1'b0; wr_ready = 1'b1;
        repeat (6) sync();
        chk("rst_no_write", wq.size(), 0);
        chk("rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
